// File: rtl/sd_sample_sequencer.sv
// Timing/address sequencer for the LVDA switch-selector sampler: strobes X2/Y2/V1/V4 per bit, drives G decode
// and availability lines, and shifts serial DATA into WORD. Optional odd-parity bit time: SD_SAMPLE_PARITY_EN.
module sd_sample_sequencer #(
    parameter int NBITS = 14,
    parameter int GRP   = 7
) (
    input  logic             SIM_CLK,
    input  logic             SIM_RST,
    input  logic             REQ,
    input  logic [1:0]       CHAN_SEL,
    input  logic             DATA,
    output logic             BUSY,
    output logic             X2,
    output logic             Y2,
    output logic             V1,
    output logic             V4,
    output logic [GRP-1:0]   GDV,
    output logic [GRP-1:0]   GDVN,
    output logic             UPPER,
    output logic             MLAV,
    output logic             PAAV,
    output logic             PBAV,
    output logic             PCAV,
    output logic             PAAVN,
    output logic [NBITS-1:0] WORD,
    output logic             WORD_VALID,
    output logic             PARITY_ERR
);

`ifdef SD_SAMPLE_PARITY_EN
    localparam int NTIMES = NBITS + 1;
`else
    localparam int NTIMES = NBITS;
`endif
    localparam int CW = $clog2(NBITS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NTIMES - 1);

    typedef enum logic [2:0] {IDLE, PH_X2, PH_Y2, PH_V1, PH_V4, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    bitIdx_q;
    logic [CW-1:0]    bitIdx_d;
    logic             x2_q, y2_q, v1_q, v4_q;
    logic [GRP-1:0]   gdv_q;
    logic [GRP-1:0]   gdv_d;
    logic             upper_q;
    logic             upper_d;
    logic [3:0]       av_q;
    logic             busy_q;
    logic             wordValid_q;
    logic [NBITS-1:0] word_q;
`ifdef SD_SAMPLE_PARITY_EN
    logic             parityBit_q;
`endif

    // Values for the next bit time: G position rotates modulo GRP alongside the bit index.
    assign bitIdx_d = bitIdx_q + 1'b1;
    assign gdv_d    = gdv_q[GRP-1] ? GRP'(1) : (gdv_q << 1);
    assign upper_d  = (32'(bitIdx_d) >= 32'(GRP));

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_q     <= IDLE;
            bitIdx_q    <= '0;
            x2_q        <= 1'b0;
            y2_q        <= 1'b0;
            v1_q        <= 1'b0;
            v4_q        <= 1'b0;
            gdv_q       <= '0;
            upper_q     <= 1'b0;
            av_q        <= 4'b0000;
            busy_q      <= 1'b0;
            wordValid_q <= 1'b0;
            word_q      <= '0;
`ifdef SD_SAMPLE_PARITY_EN
            parityBit_q <= 1'b0;
`endif
        end else begin
            wordValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (REQ) begin
                        state_q  <= PH_X2;
                        bitIdx_q <= '0;
                        x2_q     <= 1'b1;
                        gdv_q    <= GRP'(1);
                        upper_q  <= 1'b0;
                        av_q     <= 4'b0001 << CHAN_SEL;
                        busy_q   <= 1'b1;
                    end
                end
                PH_X2: begin
                    state_q <= PH_Y2;
                    x2_q    <= 1'b0;
                    y2_q    <= 1'b1;
                end
                PH_Y2: begin
                    state_q <= PH_V1;
                    y2_q    <= 1'b0;
                    v1_q    <= 1'b1;
                end
                PH_V1: begin
                    state_q <= PH_V4;
                    v1_q    <= 1'b0;
                    v4_q    <= 1'b1;
                end
                PH_V4: begin
                    v4_q <= 1'b0;
`ifdef SD_SAMPLE_PARITY_EN
                    if (bitIdx_q == CW'(NBITS)) begin
                        parityBit_q <= DATA;
                    end else begin
                        word_q <= {word_q[NBITS-2:0], DATA};
                    end
`else
                    word_q <= {word_q[NBITS-2:0], DATA};
`endif
                    if (bitIdx_q == LAST_IDX) begin
                        state_q     <= DONE;
                        av_q        <= 4'b0000;
                        gdv_q       <= '0;
                        upper_q     <= 1'b0;
                        wordValid_q <= 1'b1;
                    end else begin
                        state_q  <= PH_X2;
                        bitIdx_q <= bitIdx_d;
                        x2_q     <= 1'b1;
                        gdv_q    <= gdv_d;
                        upper_q  <= upper_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign X2         = x2_q;
    assign Y2         = y2_q;
    assign V1         = v1_q;
    assign V4         = v4_q;
    assign GDV        = gdv_q;
    assign GDVN       = ~gdv_q;
    assign UPPER      = upper_q;
    assign MLAV       = av_q[0];
    assign PAAV       = av_q[1];
    assign PBAV       = av_q[2];
    assign PCAV       = av_q[3];
    assign PAAVN      = ~av_q[1];
    assign BUSY       = busy_q;
    assign WORD       = word_q;
    assign WORD_VALID = wordValid_q;
`ifdef SD_SAMPLE_PARITY_EN
    assign PARITY_ERR = wordValid_q & ~(^word_q ^ parityBit_q);
`else
    assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_sd_sample_sequencer.sv
// Directed self-checking bench for sd_sample_sequencer with an expected-word scoreboard.
// Parity sequences are added when SD_SAMPLE_PARITY_EN is defined.
module tb_sd_sample_sequencer;

    localparam int NBITS = 14;
    localparam int GRP   = 7;
`ifdef SD_SAMPLE_PARITY_EN
    localparam int NTIMES = NBITS + 1;
`else
    localparam int NTIMES = NBITS;
`endif

    logic             SIM_CLK = 1'b0;
    logic             SIM_RST, REQ, DATA;
    logic [1:0]       CHAN_SEL;
    logic             BUSY, X2, Y2, V1, V4, UPPER;
    logic [GRP-1:0]   GDV, GDVN;
    logic             MLAV, PAAV, PBAV, PCAV, PAAVN;
    logic [NBITS-1:0] WORD;
    logic             WORD_VALID, PARITY_ERR;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int validCyc = 0;
    logic [NBITS:0] sb[$];

    sd_sample_sequencer #(.NBITS(NBITS), .GRP(GRP)) dut (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .REQ(REQ), .CHAN_SEL(CHAN_SEL), .DATA(DATA),
        .BUSY(BUSY), .X2(X2), .Y2(Y2), .V1(V1), .V4(V4), .GDV(GDV), .GDVN(GDVN), .UPPER(UPPER),
        .MLAV(MLAV), .PAAV(PAAV), .PBAV(PBAV), .PCAV(PCAV), .PAAVN(PAAVN),
        .WORD(WORD), .WORD_VALID(WORD_VALID), .PARITY_ERR(PARITY_ERR)
    );

    always #5 SIM_CLK = ~SIM_CLK;
    always @(posedge SIM_CLK) cycle <= cycle + 1;

    task automatic tick();
        @(posedge SIM_CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " strobes"}, 32'({X2, Y2, V1, V4}), 32'h0);
        checkOutput({tag, " gdv"}, 32'(GDV), 32'h0);
        checkOutput({tag, " gdvn"}, 32'(GDVN), 32'h7F);
        checkOutput({tag, " av"}, 32'({MLAV, PAAV, PBAV, PCAV}), 32'h0);
        checkOutput({tag, " misc"}, 32'({UPPER, PAAVN, BUSY, WORD_VALID, PARITY_ERR}), 32'b01000);
        checkOutput({tag, " word"}, 32'(WORD), 32'h0);
    endtask

    // bits[i] is the DATA value presented during the V4 phase of bit time i.
    task automatic applyStimulus(input logic [1:0] chan, input logic [15:0] bits,
                                 input bit holdReq, input bit noiseReq, input int abortBit);
        logic [NBITS-1:0] expWord;
        logic             expPerr;
        logic [NBITS:0]   exp;
        logic [GRP-1:0]   expG;
        int               startCyc;
        expWord = '0;
        for (int i = 0; i < NBITS; i++) expWord = {expWord[NBITS-2:0], bits[i]};
`ifdef SD_SAMPLE_PARITY_EN
        expPerr = ~(^expWord ^ bits[NBITS]);
`else
        expPerr = 1'b0;
`endif
        CHAN_SEL = chan;
        REQ = 1'b1;
        tick();
        startCyc = cycle;
        sb.push_back({expPerr, expWord});
        REQ = holdReq;
        CHAN_SEL = ~chan;
        for (int i = 0; i < NTIMES; i++) begin
            for (int p = 0; p < 4; p++) begin
                if (i == abortBit && p == 1) begin
                    SIM_RST = 1'b1;
                    tick();
                    SIM_RST = 1'b0;
                    REQ = 1'b0;
                    checkReset("abort");
                    void'(sb.pop_back());
                    return;
                end
                expG = GRP'(1) << (i % GRP);
                checkOutput($sformatf("strobe b%0d p%0d", i, p), 32'({X2, Y2, V1, V4}), 32'(4'b1000 >> p));
                checkOutput($sformatf("gdv b%0d p%0d", i, p), 32'({GDV, GDVN}), 32'({expG, ~expG}));
                checkOutput($sformatf("av b%0d p%0d", i, p), 32'({MLAV, PAAV, PBAV, PCAV, PAAVN}),
                            32'({4'b1000 >> chan, chan != 2'd1}));
                checkOutput($sformatf("misc b%0d p%0d", i, p), 32'({UPPER, BUSY, WORD_VALID, PARITY_ERR}),
                            32'({i >= GRP, 3'b100}));
                if (noiseReq) REQ = (p == 1);
                DATA = (p == 3) ? bits[i] : 1'b0;
                tick();
            end
        end
        DATA = 1'b0;
        REQ = holdReq;
        checkOutput("done valid", 32'(WORD_VALID), 32'h1);
        checkOutput("done latency", 32'(cycle - startCyc + 1), 32'(4 * NTIMES + 1));
        checkOutput("done ctl", 32'({X2, Y2, V1, V4, MLAV, PAAV, PBAV, PCAV, BUSY}), 32'h1);
        if (WORD_VALID === 1'b1 && sb.size() > 0) begin
            exp = sb.pop_front();
            checkOutput("done word", 32'(WORD), 32'(exp[NBITS-1:0]));
            checkOutput("done parity", 32'(PARITY_ERR), 32'(exp[NBITS]));
        end
        validCyc = cycle;
        tick();
        checkOutput("idle ctl", 32'({X2, BUSY, WORD_VALID, PARITY_ERR, MLAV, PAAV, PBAV, PCAV}), 32'h0);
    endtask

    task automatic countQuiet(input string tag, input int n);
        int pulses = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (WORD_VALID !== 1'b0) pulses++;
        end
        checkOutput(tag, 32'(pulses), 32'h0);
    endtask

    initial begin
        int v1;
        SIM_RST = 1'b1;
        REQ = 1'b1;
        CHAN_SEL = 2'd0;
        DATA = 1'b0;
        tick();
        tick();
        checkReset("reset");
        SIM_RST = 1'b0;
        REQ = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checkReset($sformatf("idle%0d", k));
        end

        applyStimulus(2'd1, 16'h2005, 1'b0, 1'b0, -1);
        checkOutput("word 2801 held", 32'(WORD), 32'h2801);

        applyStimulus(2'd3, 16'($urandom), 1'b1, 1'b0, -1);
        v1 = validCyc;
        applyStimulus(2'd3, 16'($urandom), 1'b1, 1'b0, -1);
        checkOutput("gap1", 32'(validCyc - v1), 32'(4 * NTIMES + 2));
        v1 = validCyc;
        applyStimulus(2'd3, 16'h3FFF, 1'b0, 1'b0, -1);
        checkOutput("gap2", 32'(validCyc - v1), 32'(4 * NTIMES + 2));

        applyStimulus(2'd2, 16'h3FFF, 1'b0, 1'b0, 5);
        countQuiet("no valid after abort", 4 * NTIMES + 10);
        checkOutput("word after abort", 32'(WORD), 32'h0);
        checkOutput("sb empty after abort", 32'(sb.size()), 32'h0);
        applyStimulus(2'd0, 16'($urandom), 1'b0, 1'b0, -1);

        applyStimulus(2'd0, 16'h1234, 1'b0, 1'b1, -1);
        countQuiet("no queued req", 4 * NTIMES + 10);

`ifdef SD_SAMPLE_PARITY_EN
        applyStimulus(2'd1, 16'h2000, 1'b0, 1'b0, -1);
        checkOutput("parity word", 32'(WORD), 32'h0001);
        applyStimulus(2'd1, 16'h6000, 1'b0, 1'b0, -1);
        checkOutput("parity word 2", 32'(WORD), 32'h0001);
`endif

        checkOutput("sb drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
